// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, FSM state enum and the multi-cycle op decoder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a. MULDIV_REM_EN adds REMU decoding (funct3=110, Type_alu=0).
package alu_pkg;

  localparam logic [2:0] F3_MULDIV = 3'b011;
  localparam logic [2:0] F3_REMU   = 3'b110;
  localparam logic       TYPE_MUL  = 1'b1;
  localparam logic       TYPE_DIV  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_MUL,
    OP_DIVU,
    OP_REMU
  } md_op_e;

  // Map the raw op fields onto the multi-cycle unit's internal op; anything unknown is OP_NONE.
  function automatic md_op_e decode_op(input logic [2:0] f3, input logic variant);
    md_op_e op;
    op = OP_NONE;
    if (f3 == F3_MULDIV && variant == TYPE_MUL) begin
      op = OP_MUL;
    end else if (f3 == F3_MULDIV && variant == TYPE_DIV) begin
      op = OP_DIVU;
    end
`ifdef MULDIV_REM_EN
    else if (f3 == F3_REMU && variant == TYPE_DIV) begin
      op = OP_REMU;
    end
`endif
    return op;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: MSB-first shift-add or restoring subtract-shift.
// Latency: purely combinational.
// Backpressure: none; the caller's FSM decides when the step result is registered.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sreg,
  input  logic [WIDTH-1:0] operand2,
  input  md_op_e           op,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] sreg_next
);

  logic [WIDTH:0] trial;

  // MUL: Horner form, acc = 2*acc + (next multiplicand bit ? operand2 : 0); low WIDTH bits only.
  // DIV: shift next dividend bit into the remainder, subtract divisor, keep it if no borrow;
  //      the quotient bit is shifted into sreg as the dividend bits move out.
  always_comb begin
    acc_next  = acc;
    sreg_next = sreg;
    trial     = {acc, sreg[WIDTH-1]} - {1'b0, operand2};
    unique case (op)
      OP_MUL: begin
        acc_next  = {acc[WIDTH-2:0], 1'b0} + (sreg[WIDTH-1] ? operand2 : '0);
        sreg_next = {sreg[WIDTH-2:0], 1'b0};
      end
      OP_DIVU, OP_REMU: begin
        if (trial[WIDTH]) begin
          acc_next  = {acc[WIDTH-2:0], sreg[WIDTH-1]};
          sreg_next = {sreg[WIDTH-2:0], 1'b0};
        end else begin
          acc_next  = trial[WIDTH-1:0];
          sreg_next = {sreg[WIDTH-2:0], 1'b1};
        end
      end
      default: begin
        acc_next  = acc;
        sreg_next = sreg;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL / DIVU (and REMU when MULDIV_REM_EN is defined), one bit per cycle.
// Latency: done at T+WIDTH+1 after start accepted at T; unsupported op or zero divisor: T+1.
// Backpressure: start is only sampled in IDLE; starts while busy or in DONE are dropped.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       funct3_alu,
  input  logic             Type_alu,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  md_op_e           op_q;
  md_op_e           op_in;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] op2_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sreg_nxt;
  logic [WIDTH-1:0] res_sel;
  logic             div_zero;

  assign op_in    = decode_op(funct3_alu, Type_alu);
  assign div_zero = (operand2 == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .sreg     (sreg_q),
    .operand2 (op2_q),
    .op       (op_q),
    .acc_next (acc_nxt),
    .sreg_next(sreg_nxt)
  );

  // Pick the final value: product and remainder live in acc, quotient in the shift register.
  always_comb begin
    res_sel = '0;
    unique case (op_q)
      OP_MUL:  res_sel = acc_q;
      OP_DIVU: res_sel = sreg_q;
      OP_REMU: res_sel = acc_q;
      default: res_sel = '0;
    endcase
  end

  // Control FSM with registered busy/done/result; zero-divisor results are preloaded at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_NONE;
      acc_q  <= '0;
      sreg_q <= '0;
      op2_q  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op_in;
            op2_q  <= operand2;
            cnt    <= '0;
            acc_q  <= (op_in == OP_REMU && div_zero) ? operand1 : '0;
            sreg_q <= (op_in == OP_DIVU && div_zero) ? '1 : operand1;
            if (op_in != OP_NONE && !div_zero) begin
              state <= S_CALC;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_CALC: begin
          acc_q  <= acc_nxt;
          sreg_q <= sreg_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          done   <= 1'b1;
          result <= res_sel;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, busy window, ignored starts and reset abort.
// Latency: n/a.
// Backpressure: stray starts are injected while the unit is busy or in DONE.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [2:0]   f3;
  logic         type_alu;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operand1  (op1),
    .operand2  (op2),
    .funct3_alu(f3),
    .Type_alu  (type_alu),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs and inject stray starts while it runs, then score it.
  task automatic run_op(input string tag, input logic [2:0] fc, input logic ty,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input int exp_lat);
    int k;
    int busy_cnt;
    logic [W-1:0] exp;
    @(negedge clk);
    f3 = fc; type_alu = ty; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    k = 0;
    busy_cnt = busy ? 1 : 0;
    start = 1'b1; op1 = $urandom; op2 = $urandom;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (busy) busy_cnt++;
      start = (k == 5);
      op1 = $urandom; op2 = $urandom;
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat"}, k, exp_lat);
    exp = exp_q.pop_front();
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, busy_cnt, (exp_lat == 1) ? 0 : W);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int seen;
    rst = 1'b1; start = 1'b0; f3 = 3'b011; type_alu = 1'b1; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    // start coincident with reset must be ignored
    @(negedge clk); start = 1'b1; op1 = 7; op2 = 6;
    @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, '0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_prio_busy", busy, 1'b0);

    run_op("mul_7x6", 3'b011, 1'b1, 7, 6, 42, 33);
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    run_op("mul_big", 3'b011, 1'b1, a, b, a * b, 33);
    run_op("mul_ones", 3'b011, 1'b1, '1, '1, 1, 33);
    run_op("divu_100_7", 3'b011, 1'b0, 100, 7, 14, 33);
    a = 32'hDEAD_BEEF; b = 32'h0000_1234;
    run_op("divu_big", 3'b011, 1'b0, a, b, a / b, 33);
    run_op("divu_small", 3'b011, 1'b0, 3, 9, 0, 33);
    run_op("divu_zero", 3'b011, 1'b0, 5, 0, '1, 1);
    run_op("unsup_000", 3'b000, 1'b1, 7, 6, 0, 1);
    run_op("unsup_000b", 3'b000, 1'b0, 9, 3, 0, 1);
`ifdef MULDIV_REM_EN
    run_op("remu_100_7", 3'b110, 1'b0, 100, 7, 2, 33);
    run_op("remu_zero", 3'b110, 1'b0, 77, 0, 77, 1);
`else
    run_op("remu_off", 3'b110, 1'b0, 100, 7, 0, 1);
`endif
    run_op("divu_max_1", 3'b011, 1'b0, '1, 1, '1, 33);

    // reset in the middle of CALC discards the op and the stray start
    @(negedge clk); f3 = 3'b011; type_alu = 1'b1; op1 = 3; op2 = 5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin start = 1'b1; op1 = 11; op2 = 13; end
      else start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, '0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("midrst_discard", seen, 0);
    run_op("post_rst_mul", 3'b011, 1'b1, 9, 9, 81, 33);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port: operand1  input  WIDTH  multiplicand/dividend.
REQ-006 SHALL have port: operand2  input  WIDTH  multiplier/divisor.
REQ-007 SHALL have port: funct3_alu  input  3  op select.
REQ-008 SHALL have port: Type_alu  input  1  op variant.
REQ-009 SHALL have port: busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: result  output  WIDTH  registered result, held until next accepted start.

Function
REQ-012 SHALL decode ops: funct3_alu=011, Type_alu=1 -> MUL, low WIDTH bits of unsigned product; funct3_alu=011, Type_alu=0 -> DIVU, unsigned quotient.
REQ-013 SHALL treat every other op code as unsupported: done at T+1, result 0 (except REQ-024).
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on start with a supported op and nonzero divisor; CALC->DONE when the iteration counter reaches WIDTH-1; DONE->IDLE unconditionally.
REQ-015 SHALL latch operand1, operand2 and the op on the accepting edge; later input changes SHALL have no effect on the result.
REQ-016 SHALL perform one shift-add step (MUL) or one restoring subtract-shift step (DIVU) per CALC cycle, WIDTH steps total.
REQ-017 SHALL, for start accepted at edge T, assert done and update result at edge T+WIDTH+1 (T+33 for WIDTH=32); busy high T+1..T+WIDTH.
REQ-018 SHALL handle DIVU with operand2=0 by skipping CALC: result all-ones, done at T+1.
REQ-019 SHALL ignore start while busy or in DONE, with no effect on the op in progress.
REQ-020 SHALL accept a start in the cycle after done (back-to-back issue).
REQ-021 SHALL use a log2(WIDTH)-bit iteration counter; it SHALL clear on every accepted start.

Reset
REQ-022 SHALL, with rst high at any edge including mid-CALC, force state IDLE, busy=0, done=0, result=0, counter=0, and discard the op in progress.
REQ-023 SHALL give rst priority over start in the same cycle.

Configuration
REQ-024 SHALL, with MULDIV_REM_EN defined, support funct3_alu=110, Type_alu=0 -> REMU (unsigned remainder, same latency as DIVU; divisor 0 -> result=operand1 at T+1); without MULDIV_REM_EN that code SHALL be unsupported per REQ-013.

Structure
REQ-025 SHALL take the op-code constants (the funct3 values and Type_alu variants) and the FSM state enum from the shared package alu_pkg, the same package the single-cycle ALU uses.
REQ-026 SHALL place the single-iteration datapath in one combinational sub-module muldiv_step (inputs: partial accumulator, shift register, operand2, op; outputs: next accumulator and shift register).

Verification
REQ-027 SHALL cover: start, MUL, 7 x 6 -> done at T+33, result 42, busy high for 32 cycles.
REQ-028 SHALL cover: DIVU 100 / 7 -> result 14 at T+33; DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF.
REQ-029 SHALL cover: DIVU 5 / 0 -> done at T+1, result 0xFFFFFFFF, busy never asserted.
REQ-030 SHALL cover: start during CALC with different operands, then rst at T+10 -> the second start is ignored; after rst, done=0, result=0, state IDLE.
REQ-031 SHALL cover: with MULDIV_REM_EN, REMU 100 % 7 -> 2 at T+33; without the macro the same code -> result 0 at T+1.
